// File: rtl/adapt_speed_ctl.sv
// ADPCM (G.721/G.726) adaptation speed control: DMS/DML averages, AP speed control, AL limiter.
// Define ADAPT_SPD_AL_REG_EN to register AL instead of deriving it combinationally from AP.
module adapt_speed_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  I,
  input  logic [12:0] Y,
  input  logic        TDP,
  input  logic        TR,
  output logic [6:0]  AL,
  output logic [9:0]  AP,
  output logic [11:0] DMS,
  output logic [13:0] DML
);

  logic [2:0]         im;
  logic [2:0]         fi;
  logic signed [12:0] dif_a;
  logic [11:0]        inc_a;
  logic [11:0]        dmsp;
  logic signed [14:0] dif_b;
  logic [13:0]        inc_b;
  logic [13:0]        dmlp;
  logic signed [14:0] dif_c;
  logic [14:0]        difm;
  logic [10:0]        dthr;
  logic               ax;
  logic signed [10:0] dif_d;
  logic [9:0]         inc_d;
  logic [9:0]         app;
  logic [9:0]         apr;

  function automatic logic [6:0] lima(input logic [9:0] a);
    return (a >= 10'd256) ? 7'd64 : {1'b0, a[7:2]};
  endfunction

  always_comb begin
    im = I[3] ? ~I[2:0] : I[2:0];
    unique case (im)
      3'd3, 3'd4, 3'd5: fi = 3'd1;
      3'd6:             fi = 3'd3;
      3'd7:             fi = 3'd7;
      default:          fi = 3'd0;
    endcase
  end

  // Shift results are truncated to the register width; adds wrap modulo 2^N.
  always_comb begin
    dif_a = {1'b0, fi, 9'b0} - {1'b0, DMS};
    inc_a = 12'(dif_a >>> 5);
    dmsp  = DMS + inc_a;

    dif_b = {1'b0, fi, 11'b0} - {1'b0, DML};
    inc_b = 14'(dif_b >>> 7);
    dmlp  = DML + inc_b;

    dif_c = {1'b0, dmsp, 2'b0} - {1'b0, dmlp};
    difm  = dif_c[14] ? 15'(-dif_c) : 15'(dif_c);
    dthr  = dmlp[13:3];
    ax    = !((Y >= 13'd1536) && (difm < {4'b0, dthr}) && !TDP);

    dif_d = {1'b0, ax, 9'b0} - {1'b0, AP};
    inc_d = 10'(dif_d >>> 4);
    app   = AP + inc_d;

    apr   = TR ? 10'd256 : app;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DMS <= '0;
      DML <= '0;
      AP  <= '0;
    end else if (en) begin
      DMS <= dmsp;
      DML <= dmlp;
      AP  <= apr;
    end
  end

`ifdef ADAPT_SPD_AL_REG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   AL <= '0;
    else if (en) AL <= lima(apr);
  end
`else
  always_comb AL = lima(AP);
`endif

endmodule

// File: tb/tb_adapt_speed_ctl.sv
// Scoreboard bench for adapt_speed_ctl: directed vectors plus an integer reference of the speed-control equations.
module tb_adapt_speed_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  I = '0;
  logic [12:0] Y = '0;
  logic        TDP = 1'b0;
  logic        TR = 1'b0;
  logic [6:0]  AL;
  logic [9:0]  AP;
  logic [11:0] DMS;
  logic [13:0] DML;

  adapt_speed_ctl dut (
    .clk(clk), .reset(reset), .en(en), .I(I), .Y(Y), .TDP(TDP), .TR(TR),
    .AL(AL), .AP(AP), .DMS(DMS), .DML(DML)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    dms;
    int    dml;
    int    ap;
    int    al;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_dms = 0;
  int   m_dml = 0;
  int   m_ap = 0;

  function automatic void push(input string nm, input int d, input int l, input int a, input int q);
    exp_t e;
    e.name = nm; e.dms = d; e.dml = l; e.ap = a; e.al = q;
    sb.push_back(e);
  endfunction

  function automatic int model_al(input int a);
    return (a >= 256) ? 64 : a / 4;
  endfunction

  function automatic void push_model(input string nm);
    push(nm, m_dms, m_dml, m_ap, model_al(m_ap));
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp_v);
    if (exp_v >= 0) begin
      n_checks++;
      if (act != exp_v) begin
        n_fail++;
        $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "DMS", int'(DMS), e.dms);
        chk(e.name, "DML", int'(DML), e.dml);
        chk(e.name, "AP",  int'(AP),  e.ap);
        chk(e.name, "AL",  int'(AL),  e.al);
      end
    end
  end

  task automatic model_update(input logic [3:0] i, input int y, input logic tdp, input logic tr);
    int im, fi, d, dmsp, dmlp, diff, difm, dthr, ax, app;
    im = i[3] ? ((~int'(i)) & 7) : (int'(i) & 7);
    case (im)
      3, 4, 5: fi = 1;
      6:       fi = 3;
      7:       fi = 7;
      default: fi = 0;
    endcase
    d    = fi * 512 - m_dms;
    dmsp = (m_dms + (d >>> 5)) & 4095;
    d    = fi * 2048 - m_dml;
    dmlp = (m_dml + (d >>> 7)) & 16383;
    diff = dmsp * 4 - dmlp;
    difm = (diff < 0) ? -diff : diff;
    dthr = dmlp / 8;
    ax   = (y >= 1536 && difm < dthr && !tdp) ? 0 : 1;
    d    = ax * 512 - m_ap;
    app  = (m_ap + (d >>> 4)) & 1023;
    m_dms = dmsp;
    m_dml = dmlp;
    m_ap  = tr ? 256 : app;
  endtask

  task automatic step(input logic e, input logic [3:0] i, input logic [12:0] y,
                      input logic tdp, input logic tr, input string nm);
    @(negedge clk);
    en = e; I = i; Y = y; TDP = tdp; TR = tr;
    if (e) model_update(i, int'(y), tdp, tr);
    @(posedge clk);
    #1;
    push_model(nm);
  endtask

  task automatic rst_step(input string nm);
    @(negedge clk);
    reset = 1'b1;
    en = 1'($urandom); I = 4'($urandom); Y = 13'($urandom);
    TDP = 1'($urandom); TR = 1'($urandom);
    m_dms = 0; m_dml = 0; m_ap = 0;
    @(posedge clk);
    #1;
    push_model(nm);
  endtask

  task automatic rst_release();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs, then idle with en=0
    rst_step("rst0");
    rst_step("rst1");
    push("rst_hand", 0, 0, 0, 0);
    rst_release();
    for (int k = 0; k < 3; k++)
      step(1'b0, 4'($urandom), 13'($urandom), 1'($urandom), 1'($urandom), "idle");
    push("idle_hand", 0, 0, 0, 0);

    // 2: first sample, FI=7
    step(1'b1, 4'b0111, 13'd1000, 1'b0, 1'b0, "first");
    push("first_hand", 112, 112, 32, 8);

    // 3: TR beats TDP, then recovery with AX=1
    step(1'b1, 4'b0111, 13'd1000, 1'b1, 1'b1, "tr_tdp");
    push("tr_tdp_hand", -1, -1, 256, 64);
    step(1'b1, 4'b0111, 13'd1000, 1'b0, 1'b0, "after_tr");
    push("after_tr_hand", -1, -1, 272, 64);

    // 4: converge averages, force AP=256, then decay with AX=0
    for (int k = 0; k < 800; k++)
      step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b0, "conv");
    step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b1, "force");
    push("force_hand", -1, -1, 256, 64);
    step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b0, "decay1");
    push("decay1_hand", -1, -1, 240, 60);
    step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b0, "decay2");
    push("decay2_hand", -1, -1, 225, 56);
    step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b0, "decay3");
    push("decay3_hand", -1, -1, 210, 52);

    // 5: TDP=1 and Y=1535 both force AX=1; Y=1536 permits AX=0
    step(1'b1, 4'b0111, 13'd2000, 1'b0, 1'b1, "force2");
    push("force2_hand", -1, -1, 256, 64);
    step(1'b1, 4'b0111, 13'd2000, 1'b1, 1'b0, "tdp1");
    push("tdp1_hand", -1, -1, 272, 64);
    step(1'b1, 4'b0111, 13'd2000, 1'b1, 1'b0, "tdp2");
    push("tdp2_hand", -1, -1, 287, 64);
    step(1'b1, 4'b0111, 13'd1535, 1'b0, 1'b1, "force3");
    push("force3_hand", -1, -1, 256, 64);
    step(1'b1, 4'b0111, 13'd1535, 1'b0, 1'b0, "y1535");
    push("y1535_hand", -1, -1, 272, 64);
    step(1'b1, 4'b0111, 13'd1536, 1'b0, 1'b0, "y1536");
    push("y1536_hand", -1, -1, 255, 63);
    step(1'b1, 4'b1000, 13'd3000, 1'b0, 1'b0, "neg_code");

    // 6: hold with en=0, then reset landing mid-sample
    for (int k = 0; k < 5; k++)
      step(1'b0, 4'($urandom), 13'($urandom), 1'($urandom), 1'($urandom), "hold");
    @(negedge clk);
    en = 1'b1; I = 4'b0111; Y = 13'd1000; TDP = 1'b0; TR = 1'b1;
    #2 reset = 1'b1;
    m_dms = 0; m_dml = 0; m_ap = 0;
    @(posedge clk);
    #1;
    push("mid_rst", 0, 0, 0, 0);
    rst_release();
    step(1'b1, 4'b0000, 13'd1000, 1'b0, 1'b0, "post_rst");
    push("post_rst_hand", 0, 0, 32, 8);
    step(1'b1, 4'b1001, 13'd1600, 1'b0, 1'b0, "mixed");

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
